// File: rtl/io_pkg.sv
// Shared sizes, types and helpers for the CPU-side I/O port controller.
package io_pkg;

  localparam int NUM_PORTS = 16;
  localparam int DATA_W    = 8;
  localparam int AW        = $clog2(NUM_PORTS);
  localparam int HALT_BIT  = 0;

  typedef logic [AW-1:0]     port_addr_t;
  typedef logic [DATA_W-1:0] port_data_t;
  typedef port_data_t        port_array_t [NUM_PORTS];

  // Only meaningful when NUM_PORTS is not a power of two.
  function automatic logic addr_in_range(input port_addr_t a);
    return int'(a) < NUM_PORTS;
  endfunction

endpackage

// File: rtl/io_port_ctrl_if.sv
// CPU access bus plus the external port arrays of the I/O controller.
interface io_port_ctrl_if;
  import io_pkg::*;

  port_addr_t  io_addr;
  port_data_t  io_wdata;
  logic        io_wr;
  logic        io_rd;
  port_data_t  io_rdata;
  logic        io_ready;
  port_array_t port_in_data;
  port_array_t port_out_data;
  logic        irq;
  logic        halt;

  modport master (
    output io_addr, io_wdata, io_wr, io_rd, port_in_data,
    input  io_rdata, io_ready, port_out_data, irq, halt
  );

  modport slave (
    input  io_addr, io_wdata, io_wr, io_rd, port_in_data,
    output io_rdata, io_ready, port_out_data, irq, halt
  );

endinterface

// File: rtl/io_sync_edge.sv
// Multi-flop synchronizer for one input port plus a prev register for change detection.
module io_sync_edge
  import io_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  port_data_t i_d,
  output port_data_t o_sync_q,
  output logic       o_change
);

  port_data_t r_sync [SYNC_STAGES];
  port_data_t r_prev;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync_q = r_sync[SYNC_STAGES-1];
  assign o_change = (r_sync[SYNC_STAGES-1] != r_prev);

endmodule

// File: rtl/io_port_ctrl.sv
// Output port registers, synchronized input reads, change interrupt and sticky halt.
module io_port_ctrl
  import io_pkg::*;
#(
  parameter int                   SYNC_STAGES = 2,
  parameter int                   HALT_PORT   = 15,
  parameter logic [NUM_PORTS-1:0] IRQ_EN_MASK = '1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  io_port_ctrl_if.slave bus
);

  port_data_t           w_sync [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_change;
  logic [NUM_PORTS-1:0] w_rd_clr;
  logic                 w_wr_en;
  logic                 w_rd_acc;
  port_data_t           w_rd_data;

  logic [NUM_PORTS-1:0] r_pending;
  logic                 r_irq;
  logic                 r_halt;
  logic                 r_ready;
  port_data_t           r_rdata;

  // A simultaneous write wins over a read; halt blocks writes but not reads.
  assign w_wr_en   = bus.io_wr && !r_halt && addr_in_range(bus.io_addr);
  assign w_rd_acc  = bus.io_rd && !bus.io_wr;
  assign w_rd_data = addr_in_range(bus.io_addr) ? w_sync[bus.io_addr] : '0;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    port_data_t r_out;

    io_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_d      (bus.port_in_data[gi]),
      .o_sync_q (w_sync[gi]),
      .o_change (w_change[gi])
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        r_out <= '0;
      end else if (w_wr_en && (bus.io_addr == port_addr_t'(gi))) begin
        r_out <= bus.io_wdata;
      end
    end

    assign bus.port_out_data[gi] = r_out;
    assign w_rd_clr[gi]          = w_rd_acc && (bus.io_addr == port_addr_t'(gi));
  end

  // A change on the same edge as a read-clear keeps the port pending.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pending <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_pending <= w_change | (r_pending & ~w_rd_clr);
      r_irq     <= |(r_pending & IRQ_EN_MASK);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_rd_acc;
      if (w_rd_acc) begin
        r_rdata <= w_rd_data;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_halt <= 1'b0;
    end else if (w_wr_en && (bus.io_addr == port_addr_t'(HALT_PORT)) && bus.io_wdata[HALT_BIT]) begin
      r_halt <= 1'b1;
    end
  end

  assign bus.io_rdata = r_rdata;
  assign bus.io_ready = r_ready;
  assign bus.irq      = r_irq;
  assign bus.halt     = r_halt;

endmodule
